snake_state_regfile: RTL and testbench
======================================

// Module: snake_state_regfile
// PURPOSE
//   Peripheral-side responder for the 0xC000_0000 GPIO window of the MIO bus.
//   Holds the snake play-field as DEPTH words of DW bits, one word per grid cell.
//   CPU writes arrive on GPIOc0000000_we/reg_addr/Peripheral_in; CPU reads return
//   on state_out. A second port gives the VGA renderer registered read access.
//   A hardware clear engine wipes the field after reset or on clr_req (game over/restart).
// PARAMETERS
//   DEPTH  768  number of cells (32x24 grid); valid addresses 0..DEPTH-1
//   AW     10   address width of reg_addr and vga_addr
//   DW     32   cell word width
//   CW     11   width of occupied counter; must hold DEPTH
// PORTS
//   clk            in   1   system clock; all state updates on rising edge
//   rst            in   1   synchronous reset, active-high
//   we             in   1   CPU write strike (bus GPIOc0000000_we)
//   reg_addr       in   AW  CPU cell address (bus reg_addr = addr_bus[13:4])
//   Peripheral_in  in   DW  CPU write data
//   state_out      out  DW  CPU read data, combinational from reg_addr
//   clr_req        in   1   one-cycle pulse: start a full-field clear
//   busy           out  1   high while the clear engine runs
//   occupied       out  CW  number of cells currently holding a nonzero word
//   vga_addr       in   AW  renderer cell address
//   vga_data       out  DW  renderer read data, registered
// BEHAVIOUR
// - Reset: while rst=1: idx=0, state=CLEAR, busy=1, occupied=0, vga_data=0.
// - FSM, two states:
//   - CLEAR: each cycle writes mem[idx]=0 and increments idx.
//     After writing idx=DEPTH-1, go to IDLE; busy drops the next cycle.
//     Result: busy=1 for exactly DEPTH cycles after rst deasserts.
//   - IDLE: normal operation. clr_req=1 moves to CLEAR with idx=0.
// - Priority, highest first: rst > clr_req > we.
//   - clr_req in any state, including mid-CLEAR, restarts the sweep at idx=0 and forces occupied=0.
//   - A write in the same cycle as clr_req is dropped.
// - CPU write (IDLE, we=1, reg_addr<DEPTH):
//   - mem[reg_addr] <= Peripheral_in.
//   - occupied updated in the same edge, using the old word (combinational read-before-write):
//     old==0 and new!=0 gives +1; old!=0 and new==0 gives -1; otherwise unchanged.
//   - occupied never wraps; by construction it stays within 0..DEPTH.
// - Writes are ignored (no state change) when:
//   - reg_addr>=DEPTH; or
//   - busy=1. There is no stall on this bus, so software must poll busy (mapped elsewhere) before writing.
// - CPU read:
//   - state_out = mem[reg_addr] combinationally, zero latency, to suit the single-cycle CPU.
//   - state_out = 0 when reg_addr>=DEPTH or busy=1.
//   - A write and read of the same address in one cycle returns the old word; the new word is visible next cycle.
// - VGA read:
//   - vga_data <= mem[vga_addr] each cycle, one-cycle latency.
//   - vga_data <= 0 when vga_addr>=DEPTH or busy=1.
//   - Same-cycle CPU write to vga_addr: vga_data shows the old word.
// - occupied holds 0 throughout CLEAR and counts up from 0 in IDLE.
// TESTING
// 1. rst high 3 cycles then low -> busy=1 for exactly 768 cycles, then 0;
//    state_out=0 and occupied=0 at every address sampled.
// 2. IDLE: write 0x00000003 @5 -> next cycle state_out(@5)=3, occupied=1;
//    write 0x7 @5 -> occupied=1;
//    write 0 @5 -> occupied=0.
// 3. Write 0xA5A5A5A5 @767, then vga_addr=767 -> vga_data=0xA5A5A5A5 one cycle later;
//    vga_addr=768 -> 0.
// 4. we=1, reg_addr=800, data 0xFFFF -> no change:
//    occupied unchanged, state_out(@800)=0, all cells unchanged.
// 5. Fill cells 0..9 nonzero (occupied=10); pulse clr_req with we=1 @20 in the same cycle
//    -> write dropped, busy 768 cycles, occupied=0, cell 20 reads 0.
// 6. Pulse clr_req; at sweep idx=400 pulse clr_req again
//    -> busy stays high 401+768 cycles total; writes attempted during busy have no effect.

Source files
------------

// File: rtl/snake_state_regfile.sv
// Purpose: snake play-field cell store for the 0xC000_0000 GPIO window, with a hardware clear engine.
// Latency: CPU read combinational (0 cycles); VGA read registered (1 cycle); writes land on the next edge.
// Backpressure: none; writes are dropped while busy (clear sweep) or when out of range, so software polls busy.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   we, reg_addr, Peripheral_in  CPU write strike / cell address / write data
//   state_out                    CPU read data (combinational from reg_addr)
//   clr_req                      one-cycle pulse that (re)starts a full-field clear
//   busy                         high while the clear engine sweeps the field
//   occupied                     count of cells holding a nonzero word
//   vga_addr, vga_data           renderer read port (registered)
module snake_state_regfile #(
    parameter int DEPTH = 768,
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int CW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] reg_addr,
    input  logic [DW-1:0] Peripheral_in,
    output logic [DW-1:0] state_out,
    input  logic          clr_req,
    output logic          busy,
    output logic [CW-1:0] occupied,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_LAST   = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    logic [DW-1:0] mem [DEPTH];

    logic          cpu_in_range;
    logic          vga_in_range;
    logic [DW-1:0] cpu_old;
    logic          cpu_wr_en;
    logic          clr_wr_en;

    assign busy         = (state == S_CLEAR);
    assign cpu_in_range = ({1'b0, reg_addr} < ADDR_LIMIT);
    assign vga_in_range = ({1'b0, vga_addr} < ADDR_LIMIT);

    // Word currently stored at reg_addr; used both for the CPU read and for
    // the occupancy delta of a write in the same cycle.
    assign cpu_old   = cpu_in_range ? mem[reg_addr] : '0;
    assign state_out = busy ? '0 : cpu_old;

    // clr_req outranks a coincident CPU write, so the write is simply dropped.
    assign cpu_wr_en = !rst && !busy && !clr_req && we && cpu_in_range;
    assign clr_wr_en = !rst && busy;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state: a clear request restarts the sweep from cell 0 in either state.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (clr_req) begin
            state_nxt = S_CLEAR;
            idx_nxt   = '0;
        end else if (state == S_CLEAR) begin
            if (idx == IDX_LAST) begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end
    end

    // Single write port shared by the sweep and the CPU; the two never overlap
    // because CPU writes are only accepted outside the sweep.
    always_ff @(posedge clk) begin
        if (clr_wr_en) begin
            mem[idx] <= '0;
        end else if (cpu_wr_en) begin
            mem[reg_addr] <= Peripheral_in;
        end
    end

    // Occupancy tracks zero/nonzero transitions of the written cell, judged
    // against the word being replaced. It is held at 0 for the whole sweep.
    always_ff @(posedge clk) begin
        if (rst || clr_req) begin
            occupied <= '0;
        end else if (cpu_wr_en) begin
            if ((cpu_old == '0) && (Peripheral_in != '0)) begin
                occupied <= occupied + 1'b1;
            end else if ((cpu_old != '0) && (Peripheral_in == '0)) begin
                occupied <= occupied - 1'b1;
            end
        end
    end

    // Renderer port: reads the pre-edge contents, so a coincident CPU write to
    // the same cell shows the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_data <= '0;
        end else if (busy || !vga_in_range) begin
            vga_data <= '0;
        end else begin
            vga_data <= mem[vga_addr];
        end
    end

endmodule

// File: tb/tb_snake_state_regfile.sv
module tb_snake_state_regfile;

    localparam int DEPTH = 768;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int CW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] Peripheral_in;
    logic [DW-1:0] state_out;
    logic          clr_req;
    logic          busy;
    logic [CW-1:0] occupied;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [DEPTH];
    int            occ_model;
    logic [DW-1:0] exp_q [$];

    snake_state_regfile #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .reg_addr     (reg_addr),
        .Peripheral_in(Peripheral_in),
        .state_out    (state_out),
        .clr_req      (clr_req),
        .busy         (busy),
        .occupied     (occupied),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? model[a] : '0;
    endfunction

    // Write issued right after a negedge; the write edge has passed on return.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        reg_addr = a;
        Peripheral_in = d;
        @(negedge clk);
        we = 1'b0;
        if (int'(a) < DEPTH) begin
            if (model[a] == '0 && d != '0) occ_model++;
            else if (model[a] != '0 && d == '0) occ_model--;
            model[a] = d;
        end
    endtask

    task automatic cpu_rd(input string tag, input logic [AW-1:0] a);
        reg_addr = a;
        #1;
        check(tag, state_out, model_rd(a));
    endtask

    task automatic vga_rd(input string tag, input logic [AW-1:0] a);
        vga_addr = a;
        exp_q.push_back(model_rd(a));
        @(negedge clk);
        check(tag, vga_data, exp_q.pop_front());
    endtask

    task automatic check_occ(input string tag);
        check(tag, 32'(occupied), 32'(occ_model));
    endtask

    // Compares every cell through the CPU port; no writes happen meanwhile.
    task automatic scan(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            reg_addr = AW'(i);
            #1;
            if (state_out !== model[i]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
        @(negedge clk);
    endtask

    // Counts negedge samples with busy high. Optionally re-pulses clr_req at
    // sample restart_at and hammers random writes throughout.
    task automatic run_busy(input string tag, input int restart_at, input bit poke, output int n);
        int bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            clr_req = (n == restart_at);
            if (poke) begin
                we = 1'b1;
                reg_addr = AW'($urandom_range(0, DEPTH - 1));
                Peripheral_in = $urandom | 32'd1;
            end else begin
                reg_addr = AW'(n % DEPTH);
            end
            #1;
            if (occupied !== '0) bad++;
            if (state_out !== '0) bad++;
            if (n > 0 && vga_data !== '0) bad++;
            @(negedge clk);
            n++;
        end
        we = 1'b0;
        clr_req = 1'b0;
        check({tag, " quiet"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; we = 1'b0; clr_req = 1'b0;
        reg_addr = '0; vga_addr = '0; Peripheral_in = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        occ_model = 0;

        // 1: reset then power-up sweep
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd1);
        check("rst occupied", 32'(occupied), 32'd0);
        check("rst vga_data", vga_data, 32'd0);
        rst = 1'b0;
        run_busy("t1", -1, 1'b0, n);
        check("t1 busy cycles", 32'(n), 32'd768);
        check("t1 idle", 32'(busy), 32'd0);

        // 2: occupancy transitions and read-before-write
        cpu_rd("t2 initial @5", 10'd5);
        wr(10'd5, 32'h3);
        cpu_rd("t2 rd 3 @5", 10'd5);
        check_occ("t2 occ after 3");
        wr(10'd5, 32'h7);
        check_occ("t2 occ after 7");
        we = 1'b1; reg_addr = 10'd5; Peripheral_in = 32'h9; vga_addr = 10'd5;
        #1;
        check("t2 same-cycle cpu old", state_out, 32'h7);
        @(negedge clk);
        we = 1'b0;
        check("t2 same-cycle vga old", vga_data, 32'h7);
        model[5] = 32'h9;
        cpu_rd("t2 rd 9 @5", 10'd5);
        wr(10'd5, 32'h0);
        check_occ("t2 occ after 0");

        // 3: top cell and renderer port
        wr(10'd767, 32'hA5A5A5A5);
        check_occ("t3 occ");
        cpu_rd("t3 cpu @767", 10'd767);
        vga_rd("t3 vga @767", 10'd767);
        vga_rd("t3 vga @768", 10'd768);

        // 4: out-of-range write
        wr(10'd800, 32'hFFFF);
        check_occ("t4 occ");
        cpu_rd("t4 cpu @800", 10'd800);
        scan("t4 cells");

        // 5: clear request beats a coincident write
        wr(10'd767, 32'h0);
        for (int i = 0; i < 10; i++) wr(AW'(i), DW'(i + 1));
        check_occ("t5 occ 10");
        we = 1'b1; reg_addr = 10'd20; Peripheral_in = 32'h55; clr_req = 1'b1;
        @(negedge clk);
        we = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        occ_model = 0;
        run_busy("t5", -1, 1'b0, n);
        check("t5 busy cycles", 32'(n), 32'd768);
        check_occ("t5 occ");
        cpu_rd("t5 cell 20", 10'd20);
        scan("t5 cells");

        // 6: restart mid-sweep, writes attempted while busy
        wr(10'd3, 32'h33);
        wr(10'd700, 32'h1);
        check_occ("t6 occ 2");
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        occ_model = 0;
        run_busy("t6", 400, 1'b1, n);
        check("t6 busy cycles", 32'(n), 32'd1169);
        check_occ("t6 occ");
        scan("t6 cells");
        wr(10'd9, 32'h4);
        check_occ("t6 occ resume");
        cpu_rd("t6 rd @9", 10'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
